tile_scheduler: RTL and testbench

Sequences a tiled M×K by K×N matrix multiply over the TILE×TILE systolic array. It walks the tile index space with k innermost, then n, then m. For each tile it issues one command to the array controller over a valid/ready handshake: tile indices, operand/result base addresses, valid extents for partial edge tiles, and accumulate-clear/write-back flags. Only one tile is outstanding at a time; the next command waits for the array's tile-complete pulse.

---
 rtl/tile_scheduler_if.sv | 38 +++
 rtl/tile_scheduler.sv | 150 +++++++++++++++
 tb/tb_tile_scheduler.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_scheduler_if.sv
// Tile command channel between the scheduler and the systolic array
// controller: valid/ready command bundle plus the tile-complete pulse.
interface tile_scheduler_if #(
    parameter int IW     = 3,
    parameter int EW     = 3,
    parameter int ADDR_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [IW-1:0]     tile_m;
    logic [IW-1:0]     tile_n;
    logic [IW-1:0]     tile_k;
    logic [ADDR_W-1:0] a_base;
    logic [ADDR_W-1:0] b_base;
    logic [ADDR_W-1:0] c_base;
    logic [EW-1:0]     rows_valid;
    logic [EW-1:0]     cols_valid;
    logic [EW-1:0]     k_valid;
    logic              acc_clear;
    logic              wb_en;
    logic              tile_done;

    modport master (
        output cmd_valid, tile_m, tile_n, tile_k,
        output a_base, b_base, c_base,
        output rows_valid, cols_valid, k_valid,
        output acc_clear, wb_en,
        input  cmd_ready, tile_done
    );

    modport slave (
        input  cmd_valid, tile_m, tile_n, tile_k,
        input  a_base, b_base, c_base,
        input  rows_valid, cols_valid, k_valid,
        input  acc_clear, wb_en,
        output cmd_ready, tile_done
    );
endinterface

// File: rtl/tile_scheduler.sv
// Tile scheduler: walks the tiled matmul index space (k, then n, then m)
// and issues one command per tile, waiting for tile_done between commands.
module tile_scheduler #(
    parameter int M_SIZE = 4,
    parameter int N_SIZE = 4,
    parameter int K_SIZE = 16,
    parameter int TILE   = 4,
    parameter int ADDR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    tile_scheduler_if.master cmd,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int TM  = (M_SIZE + TILE - 1) / TILE;
    localparam int TN  = (N_SIZE + TILE - 1) / TILE;
    localparam int TK  = (K_SIZE + TILE - 1) / TILE;
    localparam int TMX = (TM > TN) ? ((TM > TK) ? TM : TK)
                                   : ((TN > TK) ? TN : TK);
    localparam int IW  = $clog2(TMX + 1);
    localparam int EW  = $clog2(TILE + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state_q;
    logic [IW-1:0] tm_q, tn_q, tk_q;
    logic [IW-1:0] tm_d, tn_d, tk_d;
    logic          last_tile;
    logic          valid_q, busy_q, done_q, err_q;
    int            rem_m, rem_n, rem_k;

    // Next tile indices (k innermost, then n, then m) and last-tile flag.
    always_comb begin
        tm_d = tm_q;
        tn_d = tn_q;
        tk_d = tk_q;
        if (tk_q == IW'(TK - 1)) begin
            tk_d = '0;
            if (tn_q == IW'(TN - 1)) begin
                tn_d = '0;
                tm_d = tm_q + IW'(1);
            end else begin
                tn_d = tn_q + IW'(1);
            end
        end else begin
            tk_d = tk_q + IW'(1);
        end
        last_tile = (tm_q == IW'(TM - 1)) && (tn_q == IW'(TN - 1))
                 && (tk_q == IW'(TK - 1));
    end

    // Sequencing FSM; abort overrides everything, stray tile_done flags err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tm_q    <= '0;
            tn_q    <= '0;
            tk_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (cmd.tile_done && state_q != WAIT) begin
                err_q <= 1'b1;
            end
            if (abort) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start) begin
                            tm_q    <= '0;
                            tn_q    <= '0;
                            tk_q    <= '0;
                            err_q   <= 1'b0;
                            state_q <= ISSUE;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                    ISSUE: begin
                        if (cmd.cmd_ready) begin
                            state_q <= WAIT;
                            valid_q <= 1'b0;
                        end
                    end
                    WAIT: begin
                        if (cmd.tile_done) begin
                            if (last_tile) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                tm_q    <= tm_d;
                                tn_q    <= tn_d;
                                tk_q    <= tk_d;
                                state_q <= ISSUE;
                                valid_q <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Command fields decoded from the registered tile indices.
    always_comb begin
        rem_m = M_SIZE - int'(tm_q) * TILE;
        rem_n = N_SIZE - int'(tn_q) * TILE;
        rem_k = K_SIZE - int'(tk_q) * TILE;
        cmd.cmd_valid  = valid_q;
        cmd.tile_m     = tm_q;
        cmd.tile_n     = tn_q;
        cmd.tile_k     = tk_q;
        cmd.a_base     = ADDR_W'(int'(tm_q) * TILE * K_SIZE
                                 + int'(tk_q) * TILE);
        cmd.b_base     = ADDR_W'(int'(tk_q) * TILE * N_SIZE
                                 + int'(tn_q) * TILE);
        cmd.c_base     = ADDR_W'(int'(tm_q) * TILE * N_SIZE
                                 + int'(tn_q) * TILE);
        cmd.rows_valid = (rem_m > TILE) ? EW'(TILE) : EW'(rem_m);
        cmd.cols_valid = (rem_n > TILE) ? EW'(TILE) : EW'(rem_n);
        cmd.k_valid    = (rem_k > TILE) ? EW'(TILE) : EW'(rem_k);
        cmd.acc_clear  = (tk_q == '0);
        cmd.wb_en      = (tk_q == IW'(TK - 1));
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
endmodule

// File: tb/tb_tile_scheduler.sv
// Bench for tile_scheduler: two configurations (4,4,16) and (6,4,6),
// directed plus randomized handshakes against a tile-list reference model.
module tb_tile_scheduler;
    logic clk = 1'b0;
    logic rst, start, abort, cmd_ready, tile_done, sel;
    logic busy0, done0, err0, busy1, done1, err1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    tile_scheduler_if #(.IW(3), .EW(3), .ADDR_W(8)) if0 ();
    tile_scheduler_if #(.IW(2), .EW(3), .ADDR_W(8)) if1 ();

    assign if0.cmd_ready = cmd_ready;
    assign if0.tile_done = tile_done;
    assign if1.cmd_ready = cmd_ready;
    assign if1.tile_done = tile_done;

    tile_scheduler #(
        .M_SIZE(4), .N_SIZE(4), .K_SIZE(16), .TILE(4), .ADDR_W(8)
    ) u0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cmd(if0), .busy(busy0), .done(done0), .err(err0)
    );

    tile_scheduler #(
        .M_SIZE(6), .N_SIZE(4), .K_SIZE(6), .TILE(4), .ADDR_W(8)
    ) u1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cmd(if1), .busy(busy1), .done(done1), .err(err1)
    );

    logic       o_valid, o_acc, o_wb, o_busy, o_done, o_err;
    logic [2:0] o_tm, o_tn, o_tk, o_rv, o_cv, o_kv;
    logic [7:0] o_a, o_b, o_c;

    always_comb begin
        if (sel) begin
            o_valid = if1.cmd_valid;
            o_tm = {1'b0, if1.tile_m};
            o_tn = {1'b0, if1.tile_n};
            o_tk = {1'b0, if1.tile_k};
            o_a = if1.a_base; o_b = if1.b_base; o_c = if1.c_base;
            o_rv = if1.rows_valid; o_cv = if1.cols_valid;
            o_kv = if1.k_valid;
            o_acc = if1.acc_clear; o_wb = if1.wb_en;
            o_busy = busy1; o_done = done1; o_err = err1;
        end else begin
            o_valid = if0.cmd_valid;
            o_tm = if0.tile_m; o_tn = if0.tile_n; o_tk = if0.tile_k;
            o_a = if0.a_base; o_b = if0.b_base; o_c = if0.c_base;
            o_rv = if0.rows_valid; o_cv = if0.cols_valid;
            o_kv = if0.k_valid;
            o_acc = if0.acc_clear; o_wb = if0.wb_en;
            o_busy = busy0; o_done = done0; o_err = err0;
        end
    end

    typedef struct {
        int tm, tn, tk, a, b, c, rv, cv, kv;
        bit acc, wb;
    } cmd_t;

    cmd_t q[$];

    function automatic int min4(input int x);
        return (x < 4) ? x : 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected command list: every tile in m, n, k order (k innermost).
    task automatic build();
        int cm, cn, ck, tmn, tnn, tkn;
        cmd_t e;
        cm = sel ? 6 : 4;
        cn = 4;
        ck = sel ? 6 : 16;
        tmn = (cm + 3) / 4;
        tnn = (cn + 3) / 4;
        tkn = (ck + 3) / 4;
        q.delete();
        for (int m = 0; m < tmn; m++)
            for (int n = 0; n < tnn; n++)
                for (int k = 0; k < tkn; k++) begin
                    e.tm = m; e.tn = n; e.tk = k;
                    e.a = m * 4 * ck + k * 4;
                    e.b = k * 4 * cn + n * 4;
                    e.c = m * 4 * cn + n * 4;
                    e.rv = min4(cm - m * 4);
                    e.cv = min4(cn - n * 4);
                    e.kv = min4(ck - k * 4);
                    e.acc = (k == 0);
                    e.wb = (k == tkn - 1);
                    q.push_back(e);
                end
    endtask

    task automatic chk_fields(input cmd_t e);
        chk("tile_m", 32'(o_tm), e.tm);
        chk("tile_n", 32'(o_tn), e.tn);
        chk("tile_k", 32'(o_tk), e.tk);
        chk("a_base", 32'(o_a), e.a);
        chk("b_base", 32'(o_b), e.b);
        chk("c_base", 32'(o_c), e.c);
        chk("rows_valid", 32'(o_rv), e.rv);
        chk("cols_valid", 32'(o_cv), e.cv);
        chk("k_valid", 32'(o_kv), e.kv);
        chk("acc_clear", 32'(o_acc), 32'(e.acc));
        chk("wb_en", 32'(o_wb), 32'(e.wb));
    endtask

    // hold_mode: 0 none, 1 random, 2 five cycles on cmd 1.
    // lat_fix: 0 random tile_done latency, else fixed.
    task automatic run_job(input int hold_mode, input int lat_fix,
                           input int abort_at, input int spur_at);
        int w, hold, lat;
        build();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start.busy", 32'(o_busy), 1);
        chk("start.err", 32'(o_err), 0);
        for (int i = 0; i < q.size(); i++) begin
            w = 0;
            while (o_valid !== 1'b1 && w < 20) begin
                @(negedge clk);
                w++;
            end
            chk("issue.valid", 32'(o_valid), 1);
            chk_fields(q[i]);
            if (hold_mode == 1) hold = $urandom_range(0, 3);
            else if (hold_mode == 2 && i == 1) hold = 5;
            else hold = 0;
            if (i == spur_at && hold == 0) hold = 1;
            cmd_ready = 1'b0;
            for (int h = 0; h < hold; h++) begin
                if (i == spur_at && h == 0) tile_done = 1'b1;
                @(negedge clk);
                tile_done = 1'b0;
                chk("hold.valid", 32'(o_valid), 1);
                chk_fields(q[i]);
            end
            if (i == spur_at) chk("spur.err", 32'(o_err), 1);
            cmd_ready = 1'b1;
            @(negedge clk);
            cmd_ready = 1'b0;
            chk("hs.drop", 32'(o_valid), 0);
            if (i == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk("abort.busy", 32'(o_busy), 0);
                chk("abort.valid", 32'(o_valid), 0);
                chk("abort.done", 32'(o_done), 0);
                @(negedge clk);
                chk("abort.nodone", 32'(o_done), 0);
                chk("abort.idle", 32'(o_busy), 0);
                return;
            end
            lat = (lat_fix > 0) ? lat_fix : $urandom_range(1, 6);
            repeat (lat - 1) @(negedge clk);
            tile_done = 1'b1;
            @(negedge clk);
            tile_done = 1'b0;
            if (i == q.size() - 1) begin
                chk("fin.done", 32'(o_done), 1);
                chk("fin.busy", 32'(o_busy), 1);
                chk("fin.valid", 32'(o_valid), 0);
                @(negedge clk);
                chk("fin.done_low", 32'(o_done), 0);
                chk("fin.busy_low", 32'(o_busy), 0);
            end else begin
                chk("next.valid", 32'(o_valid), 1);
            end
        end
        if (spur_at >= 0) chk("spur.sticky", 32'(o_err), 1);
    endtask

    task automatic do_reset(input logic s);
        rst = 1'b1;
        start = 1'b0; abort = 1'b0; cmd_ready = 1'b0; tile_done = 1'b0;
        sel = s;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0; abort = 1'b0; cmd_ready = 1'b0; tile_done = 1'b0;
        sel = 1'b0;
        @(negedge clk);
        chk("rst.valid", 32'(o_valid), 0);
        chk("rst.busy", 32'(o_busy), 0);
        chk("rst.done", 32'(o_done), 0);
        chk("rst.err", 32'(o_err), 0);
        build();
        chk_fields(q[0]);
        sel = 1'b1;
        #1;
        build();
        chk_fields(q[0]);
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        run_job(0, 6, -1, -1);

        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_start.busy", 32'(o_busy), 0);
        chk("abort_start.valid", 32'(o_valid), 0);

        run_job(2, 0, -1, -1);
        run_job(0, 3, 2, -1);
        run_job(0, 2, -1, -1);
        run_job(1, 0, -1, 1);
        run_job(1, 0, -1, -1);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mid.valid", 32'(o_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("async.valid", 32'(o_valid), 0);
        chk("async.busy", 32'(o_busy), 0);
        chk("async.done", 32'(o_done), 0);
        @(negedge clk);
        rst = 1'b0;
        run_job(1, 0, -1, -1);

        do_reset(1'b1);
        run_job(0, 6, -1, -1);
        run_job(2, 0, -1, -1);
        run_job(1, 0, -1, 2);
        for (int r = 0; r < 4; r++) run_job(1, 0, -1, -1);

        do_reset(1'b0);
        for (int r = 0; r < 4; r++) run_job(1, 0, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
